// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU and
// immediate-extender codes, data-processing commands and condition mnemonics.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   // Data-processing command field, Instr[24:21] == Funct[4:1]
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   typedef enum logic [3:0] {
      C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
      C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
      C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
      C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
   } cond_t;

   function automatic logic [1:0] imm_src(input logic [1:0] op);
      case (op)
         2'b01:   imm_src = IMM_MEM;
         2'b10:   imm_src = IMM_BR;
         default: imm_src = IMM_DP;
      endcase
   endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register and condition-field evaluation; flags are only written
// on an execute-state edge when the instruction's own condition passes.
module arm_cond_unit
   import arm_ctrl_pkg::*;
#(
   parameter bit NV_IS_ALWAYS = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   input  logic       exec,
   output logic       cond_ex
);

   logic [3:0] flags;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         C_EQ: cond_ex = z;
         C_NE: cond_ex = ~z;
         C_CS: cond_ex = c;
         C_CC: cond_ex = ~c;
         C_MI: cond_ex = n;
         C_PL: cond_ex = ~n;
         C_VS: cond_ex = v;
         C_VC: cond_ex = ~v;
         C_HI: cond_ex = c & ~z;
         C_LS: cond_ex = ~c | z;
         C_GE: cond_ex = (n == v);
         C_LT: cond_ex = (n != v);
         C_GT: cond_ex = ~z & (n == v);
         C_LE: cond_ex = z | (n != v);
         C_AL: cond_ex = 1'b1;
         C_NV: cond_ex = NV_IS_ALWAYS;
         default: cond_ex = 1'b0;
      endcase
   end

   // cond_ex is taken from the pre-update flags, so an instruction never
   // predicates itself on its own result
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else if (exec && cond_ex) begin
         if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
         if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
      end
   end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, ALU decode and condition-gated
// write enables around the flag/condition sub-unit.
module arm_multicycle_ctrl
   import arm_ctrl_pkg::*;
#(
   parameter bit NV_IS_ALWAYS = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] RegSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUControl,
   output logic [3:0] State
);

   state_t     state;
   state_t     st;
   logic       irw, nextpc, regw, memw, branch, aluop;
   logic [1:0] flag_w;
   logic       cond_ex, exec, pcs;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               case (Op)
                  2'b01:   state <= S_MEMADR;
                  2'b00:   state <= Funct[5] ? S_EXECUTEI : S_EXECUTER;
                  2'b10:   state <= S_BRANCH;
                  default: state <= S_FETCH;
               endcase
            end
            S_MEMADR:   state <= Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state <= S_MEMWB;
            S_EXECUTER: state <= S_ALUWB;
            S_EXECUTEI: state <= S_ALUWB;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // While reset is held the outputs look like FETCH with all writes suppressed
   assign st    = reset ? S_FETCH : state;
   assign State = st;

   always_comb begin
      irw       = 1'b0;
      nextpc    = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      branch    = 1'b0;
      aluop     = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      case (st)
         S_FETCH: begin
            irw       = 1'b1;
            nextpc    = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR:  ALUSrcB = 2'b01;
         S_MEMREAD: AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            regw      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            memw   = 1'b1;
         end
         S_EXECUTER: aluop = 1'b1;
         S_EXECUTEI: begin
            ALUSrcB = 2'b01;
            aluop   = 1'b1;
         end
         S_ALUWB: regw = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      ALUControl = ALU_ADD;
      flag_w     = 2'b00;
      if (aluop) begin
         case (Funct[4:1])
            CMD_ADD: ALUControl = ALU_ADD;
            CMD_SUB: ALUControl = ALU_SUB;
            CMD_AND: ALUControl = ALU_AND;
            CMD_ORR: ALUControl = ALU_ORR;
            default: ALUControl = ALU_ADD;
         endcase
         flag_w[1] = Funct[0];
         flag_w[0] = Funct[0] & ((Funct[4:1] == CMD_ADD) | (Funct[4:1] == CMD_SUB));
      end
   end

   assign ImmSrc = imm_src(Op);
   assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
   assign exec   = ~reset & ((state == S_EXECUTER) | (state == S_EXECUTEI));

   arm_cond_unit #(
      .NV_IS_ALWAYS(NV_IS_ALWAYS)
   ) u_cond (
      .clk      (clk),
      .reset    (reset),
      .cond     (Cond),
      .alu_flags(ALUFlags),
      .flag_w   (flag_w),
      .exec     (exec),
      .cond_ex  (cond_ex)
   );

   // FETCH writes the PC unconditionally; a write to R15 is a PC write too
   assign pcs      = branch | (regw & (Rd == 4'd15));
   assign PCWrite  = ~reset & (nextpc | (pcs & cond_ex));
   assign RegWrite = ~reset & regw & cond_ex;
   assign MemWrite = ~reset & memw & cond_ex;
   assign IRWrite  = ~reset & irw;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: instruction-level reference model, a per-cycle
// compare process, directed scenarios with literal pins, then random programs.
module tb_arm_multicycle_ctrl;

   localparam bit NV = 1'b0;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, Rd, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
   logic [3:0] State;

   arm_multicycle_ctrl #(.NV_IS_ALWAYS(NV)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state
   logic [3:0] mflags;
   bit         ev;
   int         step;
   int         e_state, e_pcw, e_mw, e_rw, e_irw, e_adr, e_regsrc;
   int         e_asa, e_asb, e_rsrc, e_imm, e_aluc;
   int         obs_state[8], obs_pcw[8], obs_rw[8], obs_mw[8];

   // Condition truth from the flag pair table: odd codes negate even codes
   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, b;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c == 4'b1110) return 1'b1;
      if (c == 4'b1111) return NV;
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cy;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cy & ~z;
         3'd5: b = (n == v);
         default: b = ~z & (n == v);
      endcase
      return b ^ c[0];
   endfunction

   // Per-state raw control word:
   // {irw,nextpc,adr,asa,asb[1:0],rsrc[1:0],aluop,regw,memw,branch}
   function automatic logic [11:0] raw(input int s);
      case (s)
         0: raw = 12'b1_1_0_1_10_10_0_0_0_0;
         1: raw = 12'b0_0_0_1_10_10_0_0_0_0;
         2: raw = 12'b0_0_0_0_01_00_0_0_0_0;
         3: raw = 12'b0_0_1_0_00_00_0_0_0_0;
         4: raw = 12'b0_0_0_0_00_01_0_1_0_0;
         5: raw = 12'b0_0_1_0_00_00_0_0_1_0;
         6: raw = 12'b0_0_0_0_00_00_1_0_0_0;
         7: raw = 12'b0_0_0_0_01_00_1_0_0_0;
         8: raw = 12'b0_0_0_0_00_00_0_1_0_0;
         default: raw = 12'b0_0_0_0_01_10_0_0_0_1;
      endcase
   endfunction

   task automatic set_exp(input int s, input bit r);
      logic [11:0] w;
      bit ok, pcs;
      int ss;
      ss = r ? 0 : s;
      w  = raw(ss);
      ok = cond_ok(Cond, mflags);
      pcs = w[0] | (w[2] & (Rd == 4'd15));
      e_state  = ss;
      e_irw    = r ? 0 : int'(w[11]);
      e_pcw    = r ? 0 : int'(w[10] | (pcs & ok));
      e_rw     = r ? 0 : int'(w[2] & ok);
      e_mw     = r ? 0 : int'(w[1] & ok);
      e_adr    = w[9];
      e_asa    = w[8];
      e_asb    = w[7:6];
      e_rsrc   = w[5:4];
      e_imm    = (Op == 2'b11) ? 0 : int'(Op);
      e_regsrc = {Op == 2'b01, Op == 2'b10};
      if (!w[3]) e_aluc = 0;
      else case (Funct[4:1])
         4'b0100: e_aluc = 0;
         4'b0010: e_aluc = 1;
         4'b0000: e_aluc = 2;
         4'b1100: e_aluc = 3;
         default: e_aluc = 0;
      endcase
   endtask

   // Compare process: every cycle with a valid expectation
   initial begin
      forever begin
         @(negedge clk);
         if (ev) begin
            chk("State", State, e_state);
            chk("PCWrite", PCWrite, e_pcw);
            chk("MemWrite", MemWrite, e_mw);
            chk("RegWrite", RegWrite, e_rw);
            chk("IRWrite", IRWrite, e_irw);
            chk("AdrSrc", AdrSrc, e_adr);
            chk("RegSrc", RegSrc, e_regsrc);
            chk("ALUSrcA", ALUSrcA, e_asa);
            chk("ALUSrcB", ALUSrcB, e_asb);
            chk("ResultSrc", ResultSrc, e_rsrc);
            chk("ImmSrc", ImmSrc, e_imm);
            chk("ALUControl", ALUControl, e_aluc);
            obs_state[step] = State;
            obs_pcw[step]   = PCWrite;
            obs_rw[step]    = RegWrite;
            obs_mw[step]    = MemWrite;
         end
      end
   end

   // Runs one instruction from FETCH; abort >= 0 asserts reset at that step.
   // Called at posedge+1 and returns at posedge+1.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] o,
                            input logic [5:0] f, input logic [3:0] d,
                            input logic [3:0] xflags, input int abort);
      int seq[$];
      bit ex, ok;
      Cond = c; Op = o; Funct = f; Rd = d;
      seq = '{0, 1};
      case (o)
         2'b01: if (f[0]) seq = '{0, 1, 2, 3, 4}; else seq = '{0, 1, 2, 5};
         2'b00: if (f[5]) seq = '{0, 1, 7, 8};    else seq = '{0, 1, 6, 8};
         2'b10: seq = '{0, 1, 9};
         default: ;
      endcase
      for (int i = 0; i < 8; i++) begin
         obs_state[i] = -1; obs_pcw[i] = -1; obs_rw[i] = -1; obs_mw[i] = -1;
      end
      for (int i = 0; i < seq.size(); i++) begin
         ex = (seq[i] == 6) || (seq[i] == 7);
         reset = (i == abort);
         ALUFlags = ex ? xflags : 4'($urandom);
         set_exp(seq[i], reset);
         step = i;
         ev = 1'b1;
         ok = cond_ok(Cond, mflags);
         @(posedge clk);
         if (reset) begin
            mflags = 4'b0000;
            #1;
            reset = 1'b0;
            return;
         end
         if (ex && ok && f[0]) begin
            mflags[3:2] = xflags[3:2];
            if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) mflags[1:0] = xflags[1:0];
         end
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
      ev = 1'b0; step = 0; mflags = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      set_exp(0, 1'b1);
      step = 0;
      ev = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_state", obs_state[0], 0);
      chk("rst_pcwrite", obs_pcw[0], 0);

      // ADD immediate
      run_instr(4'hE, 2'b00, 6'b101000, 4'd1, 4'b0000, -1);
      chk("addi_s2", obs_state[2], 7);
      chk("addi_s3", obs_state[3], 8);
      chk("addi_rw2", obs_rw[2], 0);
      chk("addi_rw3", obs_rw[3], 1);

      // LDR
      run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, -1);
      chk("ldr_s3", obs_state[3], 3);
      chk("ldr_s4", obs_state[4], 4);
      chk("ldr_rw4", obs_rw[4], 1);

      // SUBS sets Z, then BEQ taken
      run_instr(4'hE, 2'b00, 6'b000101, 4'd3, 4'b0100, -1);
      chk("subs_model_flags", int'(mflags), 4'b0100);
      run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
      chk("beq_pcw", obs_pcw[2], 1);

      // BNE not taken, STRNE suppressed, FETCH still writes PC
      run_instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
      chk("bne_pcw", obs_pcw[2], 0);
      run_instr(4'h1, 2'b01, 6'b011000, 4'd4, 4'b0000, -1);
      chk("strne_mw", obs_mw[3], 0);
      chk("strne_fetch_pcw", obs_pcw[0], 1);

      // ORR into R15
      run_instr(4'hE, 2'b00, 6'b111000, 4'd15, 4'b0000, -1);
      chk("mov_pc_pcw", obs_pcw[3], 1);
      chk("mov_pc_rw", obs_rw[3], 1);

      // Reset during MEMREAD of an LDR; flags cleared so BEQ falls through
      run_instr(4'hE, 2'b01, 6'b011001, 4'd5, 4'b0000, 3);
      chk("abort_rw", obs_rw[3], 0);
      chk("abort_state", obs_state[3], 0);
      run_instr(4'hE, 2'b00, 6'b101000, 4'd6, 4'b0000, -1);
      chk("after_abort_s0", obs_state[0], 0);
      chk("after_abort_s2", obs_state[2], 7);
      run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);
      chk("beq_after_reset_pcw", obs_pcw[2], 0);

      // Random programs
      for (int k = 0; k < 300; k++) begin
         logic [3:0] c, d, xf;
         logic [1:0] o;
         logic [5:0] f;
         int ab;
         c  = 4'($urandom);
         o  = 2'($urandom);
         f  = 6'($urandom);
         if ($urandom_range(0, 1) == 0) f[4:1] = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'b0010;
         d  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
         xf = 4'($urandom);
         ab = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 4) : -1;
         run_instr(c, o, f, d, xf, ab);
      end

      ev = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Control unit for the multicycle ARM datapath. It sequences fetch, decode, execute, memory and writeback over several cycles. It drives the immediate extender select (ImmSrc), the ALU and mux selects, and the gated write enables. It holds the NZCV condition flags and evaluates the 4-bit condition field, so that predicated instructions become no-ops.

Parameters:
NV_IS_ALWAYS, 0, 1: Cond=1111 treated as always-true; 0: Cond=1111 never executes

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  data memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0=PC, 1=ALU result as memory address
RegSrc  out  2  [0]=1 when Op=10; [1]=1 when Op=01
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=memory data, 10=ALU result
ImmSrc  out  2  Op=00→00, 01→01, 10→10, 11→00
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
State  out  4  current FSM state, for debug

Behaviour:
- State register:
  - Synchronous reset → FETCH; Flags ← 0000.
  - While reset=1: PCWrite, MemWrite, RegWrite and IRWrite are forced to 0. All other outputs are decoded from FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECUTER; Op=00 with Funct[5]=1→EXECUTEI; Op=10→BRANCH; Op=11→FETCH (NOP).
  - MEMADR: Funct[0]=1→MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH; MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH; BRANCH→FETCH.
  - Latency: branch 3 cycles, store 4, data-processing 4, load 5.
- Raw per-state outputs (any signal not listed is 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 → ALUControl=00, FlagW=00.
  - ALUOp=1 → Funct[4:1]: 0100→00, 0010→01, 0000→10, 1100→11, other→00.
  - FlagW[1] (NZ) = Funct[0]. FlagW[0] (CV) = Funct[0] & (ADD|SUB).
- Condition check (combinational, on the registered Flags):
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - AL →1; 1111 per NV_IS_ALWAYS.
- Gated outputs:
  - PCS = Branch | (RegW & Rd==15).
  - PCWrite = NextPC | (PCS & CondEx). RegWrite = RegW & CondEx. MemWrite = MemW & CondEx.
  - FETCH always writes the PC, irrespective of Cond.
- Flag update, at clock edge in EXECUTER/EXECUTEI only:
  - Flags[3:2] ← ALUFlags[3:2] if FlagW[1] & CondEx.
  - Flags[1:0] ← ALUFlags[1:0] if FlagW[0] & CondEx.
  - CondEx for an instruction uses the flags from before that instruction's own update.
- Reset in any state aborts the instruction: no write enable asserts in the reset cycle, and the FSM is in FETCH on the next cycle.

Decomposition:
- Package arm_ctrl_pkg holds:
  - state encoding (FETCH=0 … BRANCH=9)
  - ALUControl codes
  - ImmSrc codes
  - Cond mnemonics
- Sub-module arm_cond_unit: Flags register, condition evaluation, CondEx. It takes FlagW and an execute-state strobe as inputs.

Test Plan:
- ADD imm (Cond=1110, Op=00, Funct=101000) → State sequence 0,1,EXECUTEI,ALUWB,0. ImmSrc=00 in EXECUTEI, ALUControl=00, RegWrite=1 only in ALUWB.
- LDR (Op=01, Funct=011001) → sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB. ImmSrc=01, AdrSrc=1 in MEMREAD, ResultSrc=01 with RegWrite=1 in MEMWB.
- SUBS (Op=00, Funct=000101), ALUFlags=0100 in EXECUTER → Flags=0100. Next, BEQ (Cond=0000, Op=10) → PCWrite=1 in BRANCH, ImmSrc=10.
- Flags Z=1, then BNE (Cond=0001) → PCWrite=0 in BRANCH. Then STR with Cond=0001 → MemWrite=0 in MEMWRITE; FETCH still writes the PC.
- MOV to R15 via ORR (Rd=15, Cond=1110) → PCWrite=1 and RegWrite=1 in ALUWB.
- Reset asserted during MEMREAD of an LDR → no RegWrite, State=FETCH on the next cycle, Flags=0000.
